// File: rtl/adder_tree_pipelined.sv
// Pipelined, full-precision adder tree with a valid/ready handshake and a global stall.
// Each tree level is one registered stage, so the result appears LEVELS cycles after the beat is accepted.

module adder_tree_node #(
  parameter int W      = 8,
  parameter int SIGNED = 0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   y
);
  logic ea, eb;
  assign ea = (SIGNED != 0) ? a[W-1] : 1'b0;
  assign eb = (SIGNED != 0) ? b[W-1] : 1'b0;
  assign y  = {ea, a} + {eb, b};
endmodule

module adder_tree_pipelined #(
  parameter  int N_INPUTS = 4,
  parameter  int IN_W     = 8,
  parameter  int SIGNED   = 0,
  localparam int LEVELS   = $clog2(N_INPUTS),
  localparam int OUT_W    = IN_W + LEVELS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_INPUTS*IN_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_sum
);

  if (N_INPUTS < 2 || (N_INPUTS & (N_INPUTS - 1)) != 0) begin : g_bad_n
    $error("adder_tree_pipelined: N_INPUTS must be a power of 2 and >= 2");
  end

  logic              stall, adv;
  logic [LEVELS:1]   vld_q;
  logic [LEVELS:0]   vld_pipe;

  // A result waiting on the consumer freezes the whole pipe.
  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = ~stall;
  assign vld_pipe = {vld_q, in_valid & in_ready};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      vld_q <= '0;
    else if (adv) vld_q <= vld_pipe[LEVELS-1:0];
  end

  genvar k, i;
  for (k = 0; k <= LEVELS; k++) begin : lvl
    localparam int W = IN_W + k;
    localparam int N = N_INPUTS >> k;
    logic [N-1:0][W-1:0] sum;

    if (k == 0) begin : g_in
      assign sum = in_data;
    end else begin : g_st
      logic [N-1:0][W-1:0] nxt;
      for (i = 0; i < N; i++) begin : node
        adder_tree_node #(.W(W-1), .SIGNED(SIGNED)) u_node (
          .a (lvl[k-1].sum[2*i]),
          .b (lvl[k-1].sum[2*i+1]),
          .y (nxt[i])
        );
      end
      // Bubbles leave the stage data untouched.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                      sum <= '0;
        else if (adv && vld_pipe[k-1]) sum <= nxt;
      end
    end
  end

  assign out_valid = vld_pipe[LEVELS];
  assign out_sum   = lvl[LEVELS].sum[0];

endmodule

// File: tb/tb_adder_tree_pipelined.sv
// Self-checking bench: an unsigned and a signed tree driven with identical streams,
// checked against a plain-arithmetic lane-sum model and an in-order scoreboard.

module tb_adder_tree_pipelined;
  localparam int N = 4, IW = 8, OW = 10;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic [N*IW-1:0] in_data = '0;
  logic in_ready_u, out_valid_u, in_ready_s, out_valid_s;
  logic [OW-1:0] out_sum_u, out_sum_s;
  int pass = 0, total = 0;

  always #5 clk = ~clk;

  adder_tree_pipelined #(.N_INPUTS(N), .IN_W(IW), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data),
    .out_valid(out_valid_u), .out_ready(out_ready), .out_sum(out_sum_u));

  adder_tree_pipelined #(.N_INPUTS(N), .IN_W(IW), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_sum(out_sum_s));

  function automatic logic [OW-1:0] model(input logic [N*IW-1:0] d, input bit sgn);
    int s = 0;
    for (int j = 0; j < N; j++) begin
      logic [IW-1:0] l;
      l = d[j*IW +: IW];
      s += sgn ? int'($signed(l)) : int'(l);
    end
    return OW'(s);
  endfunction

  function automatic logic [N*IW-1:0] pack4(input int a, input int b, input int c, input int d);
    logic [IW-1:0] la, lb, lc, ld;
    la = IW'(a); lb = IW'(b); lc = IW'(c); ld = IW'(d);
    return {ld, lc, lb, la};
  endfunction

  task automatic test_reset();
    #1;
    total++; if (out_valid_u !== 1'b0 || out_valid_s !== 1'b0) $display("FAIL reset_valid got %b/%b want 0", out_valid_u, out_valid_s); else pass++;
    total++; if (out_sum_u !== '0 || out_sum_s !== '0) $display("FAIL reset_sum got %h/%h want 0", out_sum_u, out_sum_s); else pass++;
    total++; if (in_ready_u !== 1'b1 || in_ready_s !== 1'b1) $display("FAIL reset_ready got %b/%b want 1", in_ready_u, in_ready_s); else pass++;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    total++;
    if ($isunknown({out_valid_u, out_sum_u, in_ready_u, out_valid_s, out_sum_s, in_ready_s}))
      $display("FAIL reset_xfree got %b%h%b want no X", out_valid_u, out_sum_u, in_ready_u);
    else pass++;
  endtask

  task automatic test_single();
    out_ready = 1'b1; in_valid = 1'b1; in_data = pack4(255, 255, 255, 255);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (out_valid_u !== (c == 1)) $display("FAIL single_valid c=%0d got %b want %b", c, out_valid_u, c == 1); else pass++;
      if (c == 1) begin
        total++; if (out_sum_u !== 10'h3FC) $display("FAIL single_sum_u got %h want 3fc", out_sum_u); else pass++;
        total++; if (out_sum_s !== 10'h3FC) $display("FAIL single_sum_s got %h want 3fc", out_sum_s); else pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      in_valid = (c < 4);
      in_data  = pack4(c + 1, 2 * (c + 1), 3 * (c + 1), 4 * (c + 1));
      @(negedge clk);
      total++; if (out_valid_u !== (c >= 1 && c <= 4)) $display("FAIL b2b_valid c=%0d got %b want %b", c, out_valid_u, c >= 1 && c <= 4); else pass++;
      if (c >= 1 && c <= 4) begin
        total++; if (out_sum_u !== OW'(10 * c)) $display("FAIL b2b_sum c=%0d got %0d want %0d", c, out_sum_u, 10 * c); else pass++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    int idx = 0, got = 0, stall_left = 3;
    bit seen = 0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      if (out_valid_u) seen = 1;
      out_ready = !(seen && stall_left > 0);
      if (!out_ready) stall_left--;
      in_valid = (idx < 4);
      in_data  = pack4(idx + 1, 2 * (idx + 1), 3 * (idx + 1), 4 * (idx + 1));
      #1;
      if (!out_ready) begin
        total++; if (in_ready_u !== 1'b0) $display("FAIL stall_ready got %b want 0", in_ready_u); else pass++;
        total++; if (out_sum_u !== 10'd10) $display("FAIL stall_hold got %0d want 10", out_sum_u); else pass++;
      end else if (out_valid_u) begin
        got++;
        total++; if (out_sum_u !== OW'(10 * got)) $display("FAIL stall_order got %0d want %0d", out_sum_u, 10 * got); else pass++;
      end
      if (in_valid && in_ready_u) idx++;
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (got !== 4 || idx !== 4) $display("FAIL stall_count got %0d/%0d want 4/4", got, idx); else pass++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_signed();
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      in_valid = (c < 2);
      in_data  = (c == 0) ? pack4(-128, -128, -128, -128) : pack4(127, -128, 1, 0);
      @(negedge clk);
      if (c == 1) begin
        total++; if (out_sum_s !== 10'h200) $display("FAIL signed_min got %h want 200", out_sum_s); else pass++;
        total++; if (out_sum_u !== 10'h200) $display("FAIL unsigned_80 got %h want 200", out_sum_u); else pass++;
      end
      if (c == 2) begin
        total++; if (out_sum_s !== 10'h000) $display("FAIL signed_mix got %h want 000", out_sum_s); else pass++;
        total++; if (out_sum_u !== 10'h100) $display("FAIL unsigned_mix got %h want 100", out_sum_u); else pass++;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_midreset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = pack4(9, 9, 9, 9);
    @(negedge clk);
    in_data = pack4(7, 7, 7, 7);
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (out_valid_u !== 1'b1) $display("FAIL midrst_pre got %b want 1", out_valid_u); else pass++;
    rst = 1'b1; #1;
    total++; if (out_valid_u !== 1'b0 || out_sum_u !== '0) $display("FAIL midrst_async got %b/%0d want 0/0", out_valid_u, out_sum_u); else pass++;
    @(negedge clk); rst = 1'b0;
    in_valid = 1'b1; in_data = pack4(1, 2, 3, 4);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      total++; if (out_valid_u !== (c == 1)) $display("FAIL midrst_valid c=%0d got %b want %b", c, out_valid_u, c == 1); else pass++;
      if (c == 1) begin
        total++; if (out_sum_u !== 10'd10) $display("FAIL midrst_sum got %0d want 10", out_sum_u); else pass++;
      end
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] qu[$], qs[$];
    logic [OW-1:0] eu, es;
    for (int c = 0; c < 400; c++) begin
      out_ready = (c >= 360) ? 1'b1 : ($urandom_range(0, 3) != 0);
      #1;
      total++; if (in_ready_u !== !(out_valid_u && !out_ready)) $display("FAIL rnd_ready got %b want %b", in_ready_u, !(out_valid_u && !out_ready)); else pass++;
      if (out_valid_u && out_ready) begin
        if (qu.size() == 0) begin
          total++; $display("FAIL rnd_extra got %0d want none", out_sum_u);
        end else begin
          eu = qu.pop_front(); es = qs.pop_front();
          total++; if (out_sum_u !== eu || out_sum_s !== es) $display("FAIL rnd_sum got %h/%h want %h/%h", out_sum_u, out_sum_s, eu, es); else pass++;
        end
      end
      if (c < 350 && !(in_valid && !in_ready_u)) begin
        in_valid = ($urandom_range(0, 4) != 0);
        in_data  = {$urandom(), $urandom()};
      end else if (c >= 350) in_valid = 1'b0;
      #1;
      if (in_valid && in_ready_u) begin
        qu.push_back(model(in_data, 0));
        qs.push_back(model(in_data, 1));
      end
      @(negedge clk);
    end
    total++; if (qu.size() != 0) $display("FAIL rnd_drain got %0d left want 0", qu.size()); else pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_signed();
    test_midreset();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/adder_tree_pipelined.md
Name: adder_tree_pipelined

Overview:
Parametrised, pipelined successor to the team's combinational adder trees. It sums N_INPUTS lanes of IN_W bits each through log2(N_INPUTS) registered adder levels, producing a full-precision sum that never overflows. Both ends use a valid/ready handshake with a global stall, so the block can sit between streaming producers and consumers in datapath blocks.

Parameters:
N_INPUTS, 4, number of input lanes; power of 2, >= 2; any other value is an elaboration error.
IN_W, 8, width of each input lane in bits.
SIGNED, 0, 0 = lanes are unsigned and zero-extended; 1 = lanes are two's complement and sign-extended.
LEVELS, clog2(N_INPUTS), derived (localparam): number of pipeline stages.
OUT_W, IN_W+LEVELS, derived (localparam): output width.

Ports:
clk  in  1  clock; all registers update on the rising edge.
rst  in  1  reset; asynchronous, active-high.
in_valid  in  1  in_data holds a beat.
in_ready  out  1  block can accept a beat this cycle.
in_data  in  N_INPUTS*IN_W  flattened lanes; lane i is in_data[i*IN_W +: IN_W].
out_valid  out  1  out_sum holds a result.
out_ready  in  1  consumer accepts the result this cycle.
out_sum  out  OUT_W  sum of all lanes of one accepted beat.

Behaviour:
- Reset: asynchronous, active-high. While rst=1:
  - all stage valid bits = 0, all stage data registers = 0;
  - out_valid = 0, out_sum = 0, in_ready = 1.
- Stall: stall = out_valid & ~out_ready; in_ready = ~stall (combinational).
- Accept: a beat is accepted when in_valid & in_ready. Producing in_valid=1 while in_ready=0 is legal; that beat is not taken and the producer must hold it.
- Advance: every stage advances when stall=0 and holds (data and valid) when stall=1.
- Stage k (1..LEVELS):
  - holds N_INPUTS/2^k partial sums, each IN_W+k bits wide;
  - each partial sum = extend(left)+extend(right) from stage k-1 (stage 0 = in_data lanes);
  - extend is 1-bit sign-extension if SIGNED=1, else zero-extension.
- Stage valid: valid_k <= valid_(k-1) on advance; valid_0 = in_valid & in_ready.
- Data loading: stage data registers load only when advancing with valid_(k-1)=1. On bubbles they keep their old value. out_sum is meaningful only when out_valid=1.
- Outputs: out_sum = the final stage register; out_valid = valid_LEVELS.
- Latency: exactly LEVELS cycles from the acceptance edge to out_valid=1 when there is no stall.
- Throughput: one beat per cycle with out_ready held at 1.
- Ordering: results leave in acceptance order; no beat is dropped or duplicated under any out_ready pattern.
- Overflow: impossible by construction, since OUT_W carries LEVELS growth bits.
- Simultaneous events: when out_valid=1 and out_ready=1 in the same cycle as an input accept, the output retires and the new beat enters on the same edge.
- Mid-stream reset: in-flight beats are discarded; out_valid falls immediately (asynchronously); operation resumes on the first edge after rst deasserts.
- out_ready is ignored when out_valid=0 (no stall).

Test Plan:
1. Assert rst with no clock edges -> out_valid=0, out_sum=0, in_ready=1; X-free after release.
2. Defaults, single beat {255,255,255,255}, out_ready=1 -> out_valid=1 exactly 2 cycles later for 1 cycle, out_sum=1020 (10'h3FC).
3. Four back-to-back beats with lane sums 10, 20, 30, 40, out_ready=1 -> out_valid high for 4 consecutive cycles starting 2 cycles after the first beat, out_sum=10, 20, 30, 40 in order.
4. Same stream with out_ready=0 for 3 cycles once the first result appears -> out_sum held at 10, in_ready=0 during the stall, then 10, 20, 30, 40 delivered in order with no loss.
5. SIGNED=1, lanes {-128,-128,-128,-128} -> out_sum=-512 (10'h200); lanes {127,-128,1,0} -> out_sum=0.
6. Assert rst while two beats are in flight -> out_valid drops without a clock edge; after release, a new beat {1,2,3,4} yields out_sum=10 after 2 cycles and no stale results appear.
